// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate arbiter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHECK      = 2'd1,
    ENTRY_OPEN = 2'd2,
    EXIT_OPEN  = 2'd3
  } state_e;

  localparam int OCC_W             = 8;
  localparam int STAT_W            = 16;
  localparam int DEF_CAPACITY      = 8;
  localparam int DEF_OPEN_CYCLES   = 16;
  localparam int DEF_CHECK_TIMEOUT = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; adv moves the pointer just past the current winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [2*N-1:0] rot_dbl, oh_dbl;
  logic [N-1:0]   rot, oh;
  logic           found;
  int             nxt;

  always_comb begin
    rot_dbl = {req, req} >> ptr_q;
    rot     = rot_dbl[N-1:0];
    oh      = '0;
    found   = 1'b0;
    nxt     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        oh[k] = 1'b1;
        nxt   = int'(ptr_q) + k + 1;
      end
    end
    if (nxt >= N) nxt = nxt - N;
    // Rotate the offset one-hot back into absolute lane positions.
    oh_dbl = {oh, oh} << ptr_q;
    grant  = oh_dbl[2*N-1:N];
    ptr_d  = (adv && found) ? PW'(nxt) : ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Barrier/password-checker arbiter for a parking lot with occupancy tracking.
// Optional statistics counters are enabled by defining PARKING_STATS_EN.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int NUM_ENTRY     = 2,
  parameter int NUM_EXIT      = 2,
  parameter int CAPACITY      = DEF_CAPACITY,
  parameter int OPEN_CYCLES   = DEF_OPEN_CYCLES,
  parameter int CHECK_TIMEOUT = DEF_CHECK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_ENTRY-1:0] entry_req,
  input  logic [NUM_EXIT-1:0]  exit_req,
  input  logic                 pass_ok,
  input  logic                 pass_bad,
  output logic [NUM_ENTRY-1:0] entry_grant,
  output logic [NUM_EXIT-1:0]  exit_grant,
  output logic                 check_en,
  output logic                 barrier_open,
  output logic                 deny,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 underflow_err,
  output logic [STAT_W-1:0]    stat_entries,
  output logic [STAT_W-1:0]    stat_denied
);

  localparam int CNT_W = $clog2(max2(OPEN_CYCLES, CHECK_TIMEOUT) + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_ENTRY-1:0] eg_q, eg_d, ent_arb_req, ent_gnt;
  logic [NUM_EXIT-1:0]  xg_q, xg_d, ext_arb_req, ext_gnt;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 uf_q, uf_d, deny_q, deny_d, chk_q, bar_q;
  logic                 ent_adv, ext_adv;

  // While a lane owns the gate the arbiter only sees that lane, so the
  // pointer advances past the true winner even if its request was dropped.
  assign ent_arb_req = (state_q == IDLE) ? entry_req : eg_q;
  assign ext_arb_req = (state_q == IDLE) ? exit_req  : xg_q;

  rr_arbiter #(.N(NUM_ENTRY)) u_entry_arb (
    .clk(clk), .reset_n(reset_n), .req(ent_arb_req), .adv(ent_adv), .grant(ent_gnt)
  );

  rr_arbiter #(.N(NUM_EXIT)) u_exit_arb (
    .clk(clk), .reset_n(reset_n), .req(ext_arb_req), .adv(ext_adv), .grant(ext_gnt)
  );

  assign full  = (occ_q == OCC_W'(CAPACITY));
  assign empty = (occ_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eg_d    = eg_q;
    xg_d    = xg_q;
    occ_d   = occ_q;
    uf_d    = uf_q;
    deny_d  = 1'b0;
    ent_adv = 1'b0;
    ext_adv = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        eg_d  = '0;
        xg_d  = '0;
        if (|exit_req) begin
          state_d = EXIT_OPEN;
          xg_d    = ext_gnt;
        end else if (|entry_req && !full) begin
          state_d = CHECK;
          eg_d    = ent_gnt;
        end
      end
      CHECK: begin
        cnt_d = cnt_q + 1'b1;
        if (pass_bad || (!pass_ok && cnt_q == CNT_W'(CHECK_TIMEOUT - 1))) begin
          state_d = IDLE;
          cnt_d   = '0;
          eg_d    = '0;
          deny_d  = 1'b1;
          ent_adv = 1'b1;
        end else if (pass_ok) begin
          state_d = ENTRY_OPEN;
          cnt_d   = '0;
        end
      end
      ENTRY_OPEN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(OPEN_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          eg_d    = '0;
          ent_adv = 1'b1;
          if (!full) occ_d = occ_q + 1'b1;
        end
      end
      EXIT_OPEN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(OPEN_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          xg_d    = '0;
          ext_adv = 1'b1;
          if (empty) uf_d  = 1'b1;
          else       occ_d = occ_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      eg_q    <= '0;
      xg_q    <= '0;
      occ_q   <= '0;
      uf_q    <= 1'b0;
      deny_q  <= 1'b0;
      chk_q   <= 1'b0;
      bar_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eg_q    <= eg_d;
      xg_q    <= xg_d;
      occ_q   <= occ_d;
      uf_q    <= uf_d;
      deny_q  <= deny_d;
      chk_q   <= (state_d == CHECK);
      bar_q   <= (state_d == ENTRY_OPEN) || (state_d == EXIT_OPEN);
    end
  end

  assign entry_grant   = eg_q;
  assign exit_grant    = xg_q;
  assign check_en      = chk_q;
  assign barrier_open  = bar_q;
  assign deny          = deny_q;
  assign occupancy     = occ_q;
  assign underflow_err = uf_q;

`ifdef PARKING_STATS_EN
  logic [STAT_W-1:0] st_ent_q, st_den_q;
  logic              entry_done;

  assign entry_done = (state_q == ENTRY_OPEN) && (state_d == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_ent_q <= '0;
      st_den_q <= '0;
    end else begin
      if (entry_done && (st_ent_q != '1)) st_ent_q <= st_ent_q + 1'b1;
      if (deny_d && (st_den_q != '1))     st_den_q <= st_den_q + 1'b1;
    end
  end

  assign stat_entries = st_ent_q;
  assign stat_denied  = st_den_q;
`else
  assign stat_entries = '0;
  assign stat_denied  = '0;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed vector table,
// hand-written corner sequences and randomized traffic against a lane model.
module tb_parking_gate_arbiter;

  localparam int NE  = 2;
  localparam int NX  = 2;
  localparam int CAP = 2;
  localparam int OC  = 16;
  localparam int TO  = 32;

  logic          clk, reset_n;
  logic [NE-1:0] er;
  logic [NX-1:0] xr;
  logic          ok, bad;
  logic [NE-1:0] entry_grant;
  logic [NX-1:0] exit_grant;
  logic          check_en, barrier_open, deny, full, empty, underflow_err;
  logic [7:0]    occupancy;
  logic [15:0]   stat_entries, stat_denied;

  parking_gate_arbiter #(
    .NUM_ENTRY(NE), .NUM_EXIT(NX), .CAPACITY(CAP), .OPEN_CYCLES(OC), .CHECK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .entry_req(er), .exit_req(xr),
    .pass_ok(ok), .pass_bad(bad), .entry_grant(entry_grant), .exit_grant(exit_grant),
    .check_en(check_en), .barrier_open(barrier_open), .deny(deny), .occupancy(occupancy),
    .full(full), .empty(empty), .underflow_err(underflow_err),
    .stat_entries(stat_entries), .stat_denied(stat_denied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Lane-level model: what the lot is doing, who owns it, how long it has been at it.
  int m_kind;  // 0 idle, 1 checking password, 2 entry barrier up, 3 exit barrier up
  int m_own, m_t, m_pe, m_px, m_occ, m_se, m_sd;
  bit m_uf, m_deny;

  function automatic int pick(input logic [7:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    return 0;
  endfunction

  function automatic int oh2i(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_own = 0; m_t = 0; m_pe = 0; m_px = 0;
    m_occ = 0; m_se = 0; m_sd = 0; m_uf = 0; m_deny = 0;
  endtask

  task automatic model_step();
    m_deny = 0;
    case (m_kind)
      0: begin
        if (xr != 0) begin m_own = pick(8'(xr), m_px, NX); m_kind = 3; m_t = 0; end
        else if (er != 0 && m_occ < CAP) begin m_own = pick(8'(er), m_pe, NE); m_kind = 1; m_t = 0; end
      end
      1: begin
        if (bad || (!ok && m_t == TO - 1)) begin
          m_deny = 1; m_kind = 0; m_pe = (m_own + 1) % NE;
          if (m_sd < 65535) m_sd++;
        end else if (ok) begin m_kind = 2; m_t = 0; end
        else m_t++;
      end
      2: begin
        if (m_t == OC - 1) begin
          m_kind = 0; m_pe = (m_own + 1) % NE;
          if (m_occ < CAP) m_occ++;
          if (m_se < 65535) m_se++;
        end else m_t++;
      end
      default: begin
        if (m_t == OC - 1) begin
          m_kind = 0; m_px = (m_own + 1) % NX;
          if (m_occ == 0) m_uf = 1; else m_occ--;
        end else m_t++;
      end
    endcase
  endtask

  task automatic compare_all();
    chk("entry_grant", entry_grant, (m_kind == 1 || m_kind == 2) ? (1 << m_own) : 0);
    chk("exit_grant", exit_grant, (m_kind == 3) ? (1 << m_own) : 0);
    chk("check_en", check_en, m_kind == 1);
    chk("barrier_open", barrier_open, m_kind >= 2);
    chk("deny", deny, m_deny);
    chk("occupancy", occupancy, m_occ);
    chk("full", full, m_occ == CAP);
    chk("empty", empty, m_occ == 0);
    chk("underflow_err", underflow_err, m_uf);
`ifdef PARKING_STATS_EN
    chk("stat_entries", stat_entries, m_se);
    chk("stat_denied", stat_denied, m_sd);
`else
    chk("stat_entries", stat_entries, 0);
    chk("stat_denied", stat_denied, 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; er = '0; xr = '0; ok = 1'b0; bad = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Serve everything pending, answering the password check with pass_ok.
  task automatic run_idle(input int budget);
    bit done = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      ok = check_en;
      er = er & ~entry_grant;
      xr = xr & ~exit_grant;
      if (er == 0 && xr == 0 && entry_grant == 0 && exit_grant == 0 && !check_en && !barrier_open) begin
        done = 1;
        break;
      end
    end
    ok = 1'b0;
    chk("run_idle_done", done, 1);
  endtask

  typedef struct {
    logic [1:0] er, xr;
    logic       ok, bad;
    int         reps;
    logic [1:0] eg, xg;
    logic       chk, bar, dny;
    logic [7:0] occ;
  } vec_t;

  vec_t tbl[11];
  int   n, gcnt, got, prev_x;
  int   order[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    //          er     xr     ok    bad  reps  eg     xg     chk   bar   dny   occ
    tbl[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, 3, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{2'b01, 2'b00, 1'b1, 1'b0, 1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{2'b00, 2'b00, 1'b0, 1'b0, 15, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[5]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[6]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{2'b00, 2'b01, 1'b0, 1'b0, 1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b0, 15, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};

    do_reset();
    chk("reset_empty", empty, 1);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        er = tbl[i].er; xr = tbl[i].xr; ok = tbl[i].ok; bad = tbl[i].bad;
        step();
        chk("tbl_entry_grant", entry_grant, tbl[i].eg);
        chk("tbl_exit_grant", exit_grant, tbl[i].xg);
        chk("tbl_check_en", check_en, tbl[i].chk);
        chk("tbl_barrier", barrier_open, tbl[i].bar);
        chk("tbl_deny", deny, tbl[i].dny);
        chk("tbl_occupancy", occupancy, tbl[i].occ);
      end
    end
    ok = 1'b0; bad = 1'b0;

    // Underflow: exit at an empty lot still opens the barrier for OC cycles.
    do_reset();
    xr = 2'b01;
    step();
    xr = '0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!barrier_open) break;
      n++;
      step();
    end
    chk("uf_barrier_cycles", n, OC);
    chk("uf_err_set", underflow_err, 1);
    chk("uf_occupancy", occupancy, 0);

    // Exit priority then entry round-robin lane 0, lane 1.
    er = 2'b11; xr = 2'b01; prev_x = 0; gcnt = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      ok = check_en;
      if (exit_grant != 0 && prev_x == 0) order.push_back(10 + oh2i(8'(exit_grant)));
      if (entry_grant != 0 && (er & entry_grant) != 0) order.push_back(oh2i(8'(entry_grant)));
      prev_x = int'(exit_grant);
      er = er & ~entry_grant;
      xr = xr & ~exit_grant;
      if (er == 0 && xr == 0 && entry_grant == 0 && exit_grant == 0 && !check_en && !barrier_open) break;
    end
    ok = 1'b0;
    chk("rr_grant_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("rr_first_exit", order[0], 10);
      chk("rr_second_lane0", order[1], 0);
      chk("rr_third_lane1", order[2], 1);
    end
    chk("rr_occupancy", occupancy, 2);
    chk("rr_full", full, 1);
    chk("uf_sticky", underflow_err, 1);

    // Full lot: entry waits, not denied, until an exit completes.
    er = 2'b01;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("full_no_grant", entry_grant, 0);
      chk("full_no_deny", deny, 0);
    end
    xr = 2'b10; got = 0; prev_x = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      ok = check_en;
      if (prev_x != 0 && exit_grant == 0) chk("full_clears_after_exit", full, 0);
      prev_x = int'(exit_grant);
      xr = xr & ~exit_grant;
      if (entry_grant != 0) begin got = 1; er = '0; end
      if (got && entry_grant == 0 && !barrier_open && !check_en) break;
    end
    ok = 1'b0;
    chk("full_pending_granted", got, 1);
    chk("full_again", full, 1);

    // Password timeout: TO cycles of check_en, then a deny pulse.
    do_reset();
    er = 2'b10; n = 0; got = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      er = er & ~entry_grant;
      if (check_en) n++;
      if (deny) begin got = 1; break; end
    end
    chk("timeout_check_cycles", n, TO);
    chk("timeout_deny_seen", got, 1);
    chk("timeout_occupancy", occupancy, 0);

    // Reset in the middle of an open barrier.
    er = 2'b01;
    run_idle(60);
    chk("pre_reset_occ", occupancy, 1);
    er = 2'b10;
    step();
    ok = 1'b1; er = '0;
    step();
    ok = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("pre_reset_barrier", barrier_open, 1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_barrier", barrier_open, 0);
    chk("rst_entry_grant", entry_grant, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_empty", empty, 1);
    compare_all();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) er = NE'($urandom_range(0, 3));
      xr  = ($urandom_range(0, 7) == 0) ? NX'($urandom_range(1, 3)) : '0;
      ok  = ($urandom_range(0, 3) == 0);
      bad = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
